hht_pair_buffer: RTL and testbench

HHT_PAIR_BUFFER -- requirements
Module: hht_pair_buffer

---
 rtl/hht_pair_buffer.sv | 186 ++++++++++++++++++
 tb/tb_hht_pair_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hht_pair_buffer.sv
// hht_pair_buffer
//   Buffers (column, value) pairs for one sparse-matrix row job between an
//   upstream fetch engine and a consumer. A job is opened with a start pulse
//   carrying the number of pairs (csize); the block accepts exactly csize
//   writes, hands them out first-word-fall-through, and raises done once the
//   last pair has been popped. Any write or pop that cannot be honoured sets
//   a sticky error flag.
//
//   Optional feature: define HHT_BUF_ACC_EN to add a 32-bit accumulator of
//   popped values on acc; otherwise acc is tied to zero.
//
// Ports
//   Clk            clock, all state updates on the rising edge
//   Rst            synchronous active-high reset
//   start          one-cycle pulse, opens a job and samples csize
//   csize          number of pairs in the job
//   wr_en          upstream presents a pair on wr_col/wr_val
//   wr_col/wr_val  pair being written
//   full           FIFO holds DEPTH entries
//   rd_en          consumer pops the head entry
//   rd_col/rd_val  head entry (zero when empty)
//   empty          FIFO holds no entries
//   count          current occupancy
//   done           all pairs of the current job have been popped
//   err            sticky protocol-error flag
//   acc            running sum of popped values (HHT_BUF_ACC_EN only)

module hht_pair_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [31:0]              csize,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_col,
    input  logic [DW-1:0]            wr_val,
    output logic                     full,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_col,
    output logic [DW-1:0]            rd_val,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              acc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_wr_left;
    logic [31:0]   r_rd_left;
    logic          r_err;

    logic [DW-1:0] r_mem_col [DEPTH];
    logic [DW-1:0] r_mem_val [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [31:0]   w_wr_left_nxt;
    logic [31:0]   w_rd_left_nxt;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A pop is always honoured when an entry exists, so a write into a full
    // FIFO is safe whenever rd_en is also high: the head slot is being freed
    // on the same edge. start and Rst take priority over both transfers.
    assign w_wr_acc = !Rst && !start && wr_en && (r_state == ST_FILL) &&
                      (r_wr_left != '0) && (!w_full || rd_en);
    assign w_rd_acc = !Rst && !start && rd_en && !w_empty;

    assign w_wr_left_nxt = w_wr_acc ? (r_wr_left - 32'd1) : r_wr_left;
    assign w_rd_left_nxt = (w_rd_acc && (r_rd_left != '0)) ?
                           (r_rd_left - 32'd1) : r_rd_left;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wr_left <= '0;
            r_rd_left <= '0;
            r_err     <= 1'b0;
        end else if (start) begin
            // Opening a job from any state flushes whatever is buffered;
            // the error flag survives so an aborted job's fault stays visible.
            r_state   <= (csize != '0) ? ST_FILL : ST_DONE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wr_left <= csize;
            r_rd_left <= csize;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_left <= w_wr_left_nxt;
            r_rd_left <= w_rd_left_nxt;

            if ((wr_en && !w_wr_acc) || (rd_en && w_empty)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_rd_left_nxt == '0) begin
                        r_state <= ST_DONE;
                    end else if (w_wr_left_nxt == '0) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_left_nxt == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge Clk) begin
        if (w_wr_acc) begin
            r_mem_col[r_wptr] <= wr_col;
            r_mem_val[r_wptr] <= wr_val;
        end
    end

    assign full   = w_full;
    assign empty  = w_empty;
    assign count  = r_count;
    assign done   = (r_state == ST_DONE);
    assign err    = r_err;
    assign rd_col = w_empty ? '0 : r_mem_col[r_rptr];
    assign rd_val = w_empty ? '0 : r_mem_val[r_rptr];

`ifdef HHT_BUF_ACC_EN
    logic [31:0] r_acc;

    // Modulo-2^32 accumulation of the low 32 bits of the popped value.
    function automatic logic [31:0] acc_wrap_add(input logic [31:0] a,
                                                 input logic [DW-1:0] v);
        logic [31:0] v32;
        v32 = 32'(v);
        return a + v32;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst || start) begin
            r_acc <= '0;
        end else if (w_rd_acc) begin
            r_acc <= acc_wrap_add(r_acc, rd_val);
        end
    end

    assign acc = r_acc;
`else
    assign acc = '0;
`endif

endmodule

// File: tb/tb_hht_pair_buffer.sv
// Directed bench for hht_pair_buffer (DEPTH=8, DW=32).
module tb_hht_pair_buffer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [31:0] csize;
    logic        wr_en;
    logic [31:0] wr_col;
    logic [31:0] wr_val;
    logic        full;
    logic        rd_en;
    logic [31:0] rd_col;
    logic [31:0] rd_val;
    logic        empty;
    logic [3:0]  count;
    logic        done;
    logic        err;
    logic [31:0] acc;

    int checks = 0;
    int errors = 0;

`ifdef HHT_BUF_ACC_EN
    localparam logic [31:0] ACC_JOB1 = 32'd104;
`else
    localparam logic [31:0] ACC_JOB1 = 32'd0;
`endif

    hht_pair_buffer #(.DEPTH(8), .DW(32)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (start),
        .csize  (csize),
        .wr_en  (wr_en),
        .wr_col (wr_col),
        .wr_val (wr_val),
        .full   (full),
        .rd_en  (rd_en),
        .rd_col (rd_col),
        .rd_val (rd_val),
        .empty  (empty),
        .count  (count),
        .done   (done),
        .err    (err),
        .acc    (acc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic rs, input logic st, input logic [31:0] cs,
                        input logic we, input logic [31:0] wc, input logic [31:0] wv,
                        input logic re);
        Rst = rs; start = st; csize = cs;
        wr_en = we; wr_col = wc; wr_val = wv; rd_en = re;
        @(posedge Clk);
        #1;
        Rst = 1'b0; start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] cols [4];
        logic [31:0] vals [4];
        cols[0] = 32'd180; vals[0] = 32'd33;
        cols[1] = 32'd181; vals[1] = 32'd36;
        cols[2] = 32'd182; vals[2] = 32'd35;
        cols[3] = 32'd183; vals[3] = 32'd0;

        Rst = 1'b1; start = 1'b0; csize = '0;
        wr_en = 1'b0; wr_col = '0; wr_val = '0; rd_en = 1'b0;
        #2;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_acc", acc, 0);
        chk("rst_rdcol", rd_col, 0);

        // Four-pair job, in-order delivery
        step(0, 1, 4, 0, 0, 0, 0);
        chk("j1_start_count", count, 0);
        chk("j1_start_done", done, 0);
        step(0, 0, 0, 1, cols[0], vals[0], 0);
        chk("j1_fwft_col", rd_col, 180);
        chk("j1_fwft_val", rd_val, 33);
        chk("j1_fwft_empty", empty, 0);
        for (int i = 1; i < 4; i++) step(0, 0, 0, 1, cols[i], vals[i], 0);
        chk("j1_count4", count, 4);
        chk("j1_full", full, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("j1_pop%0d_col", i), rd_col, cols[i]);
            chk($sformatf("j1_pop%0d_val", i), rd_val, vals[i]);
            if (i < 3) chk($sformatf("j1_pop%0d_notdone", i), done, 0);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("j1_done", done, 1);
        chk("j1_err", err, 0);
        chk("j1_empty", empty, 1);
        chk("j1_acc", acc, ACC_JOB1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("j1_done_held", done, 1);

        // Zero-length job
        step(1, 0, 0, 0, 0, 0, 0);
        chk("z_rst_done", done, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("z_done", done, 1);
        chk("z_empty", empty, 1);

        // Fill to full, overflow drop, then write with simultaneous pop
        step(0, 1, 10, 0, 0, 0, 0);
        chk("f_start_done", done, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i, 100 + i, 0);
        chk("f_full", full, 1);
        chk("f_count8", count, 8);
        chk("f_err0", err, 0);
        step(0, 0, 0, 1, 8, 108, 0);
        chk("f_drop_err", err, 1);
        chk("f_drop_count", count, 8);
        chk("f_drop_head", rd_col, 0);
        step(0, 0, 0, 1, 8, 108, 1);
        chk("f_wrrd_count", count, 8);
        chk("f_wrrd_head", rd_col, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("f_pop%0d_col", i), rd_col, i);
            chk($sformatf("f_pop%0d_val", i), rd_val, 100 + i);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("f_drained_empty", empty, 1);
        chk("f_not_done", done, 0);

        // Write and pop together on empty: write lands, pop flagged
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 55, 1);
        chk("we_count", count, 1);
        chk("we_err", err, 1);
        chk("we_head", rd_col, 5);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("we_done", done, 1);
        chk("we_empty", empty, 1);

        // Pop on empty in FILL, then restart mid-fill
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("pe_count", count, 0);
        chk("pe_empty", empty, 1);
        chk("pe_err", err, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 20 + i, 200 + i, 0);
        chk("pe_count3", count, 3);
        chk("pe_head", rd_col, 20);
        step(0, 1, 2, 0, 0, 0, 0);
        chk("rs_count", count, 0);
        chk("rs_empty", empty, 1);
        chk("rs_err_kept", err, 1);
        chk("rs_rdcol", rd_col, 0);
        step(0, 0, 0, 1, 30, 300, 0);
        step(0, 0, 0, 1, 31, 301, 0);
        chk("rs_count2", count, 2);
        chk("rs_head0", rd_col, 30);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rs_head1", rd_col, 31);
        chk("rs_head1_val", rd_val, 301);
        chk("rs_notdone", done, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rs_done", done, 1);
        chk("rs_empty_end", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
